inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock and nRst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 2: instruction buffer entries, power of two, 2..8.
REQ-004 Ports (name  direction  width  meaning):
 clock  in  1  system clock
 nRst  in  1  synchronous active-low reset
 HBUSREQ1  out  1  bus request to arbiter
 HGRANT1  in  1  arbiter grant
 HADDR  out  32  AHB address
 HTRANS  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10)
 HREADY  in  1  AHB transfer done / wait-state release
 HRESP  in  1  AHB error response (1 = ERROR)
 HRDATA  in  32  AHB read data
 redirect_valid  in  1  branch/jump redirect strobe
 redirect_pc  in  32  redirect target
 inst_valid  out  1  instruction available to decoder
 inst_ready  in  1  decoder accepts instruction
 instruction  out  32  instruction word to decoder
 inst_pc  out  32  address of instruction
 fetch_error  out  1  bus error at fetch_err_pc; sticky until redirect
 fetch_err_pc  out  32  faulting fetch address

Function
REQ-005 FSM states SHALL be REQ, ADDR, DATA, HALT.
REQ-006 REQ: HBUSREQ1=1 while space exists (entries + outstanding < FIFO_DEPTH); HGRANT1=1 and space -> ADDR.
REQ-007 ADDR: HTRANS=NONSEQ, HADDR=fetch_pc; HREADY=1 -> DATA; else hold.
REQ-008 DATA: HTRANS=IDLE; on HREADY=1 and HRESP=0, push {fetch_pc, HRDATA} unless discard flag set, fetch_pc += 4 (wraps mod 2^32), -> ADDR if HGRANT1 and space, else REQ.
REQ-009 DATA with HREADY=1, HRESP=1: no push, fetch_error=1, fetch_err_pc=fetch_pc, -> HALT.
REQ-010 At most one transfer outstanding; HTRANS=IDLE in REQ and HALT.
REQ-011 HALT: no requests, HBUSREQ1=0; leaves only on redirect_valid.
REQ-012 Downstream: inst_valid = FIFO not empty; pop when inst_valid && inst_ready; instruction/inst_pc show head entry.
REQ-013 Push and pop in same cycle SHALL be legal at any fill level, including full.
REQ-014 redirect_valid: FIFO flushed same cycle (inst_valid=0 next cycle), fetch_pc <= redirect_pc, fetch_error cleared.
REQ-015 Redirect in ADDR with HREADY=1 or in DATA: bus transfer completes; its data discarded (discard flag), then fetch restarts at redirect_pc.
REQ-016 Redirect in REQ/HALT: next state REQ; redirect in ADDR with HREADY=0: HADDR held until HREADY, then discard as REQ-015.
REQ-017 Redirect wins over simultaneous push and pop; popped entry is lost, not delivered twice.
REQ-018 Throughput: one instruction per 2 cycles with zero wait states and grant held.

Reset
REQ-019 On nRst=0 at clock edge: state=REQ, fetch_pc=RESET_PC, FIFO empty, discard=0, HBUSREQ1=0, HTRANS=IDLE, HADDR=0, inst_valid=0, fetch_error=0, fetch_err_pc=0.
REQ-020 Reset mid-transfer SHALL abandon it; no data pushed from it.

Configuration
REQ-021 Macro IFU_MISALIGN_CHECK_EN: when defined, redirect_pc[1:0]!=0 sets fetch_error=1, fetch_err_pc=redirect_pc, state HALT, no bus request; when undefined, redirect_pc[1:0] ignored (forced to 2'b00).

Structure
REQ-022 Package ifu_pkg SHALL hold FSM state enum, HTRANS encodings, fetch entry struct {pc, instr}.
REQ-023 Buffer SHALL be sub-module fetch_fifo (sync FIFO, push/pop/flush, full/empty, count).

Verification
REQ-024 Reset, RESET_PC=0, HGRANT1=1, HREADY=1, memory word n = n -> inst_pc 0,4,8 with instruction 0,1,2, one per 2 cycles.
REQ-025 inst_ready=0 -> after 2 pushes HBUSREQ1=0, no NONSEQ; inst_ready=1 -> pc 0 delivered then fetch resumes.
REQ-026 Redirect to 0x100 during DATA of 0x8 -> 0x8 never on inst_pc; next delivered inst_pc=0x100.
REQ-027 HRESP=1 on 0xC -> fetch_error=1, fetch_err_pc=0xC, no further HTRANS=NONSEQ; redirect 0x20 clears and fetches 0x20.
REQ-028 HGRANT1 low 5 cycles, HREADY low 3 cycles in ADDR -> HADDR stable, no duplicate or lost instruction.
REQ-029 IFU_MISALIGN_CHECK_EN defined, redirect 0x102 -> fetch_error=1, fetch_err_pc=0x102; undefined -> fetch 0x100.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, AHB transfer
// encodings and the fetch buffer entry.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HALT = 2'd3
    } ifu_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// AHB master and decoder-side signals of the fetch unit, bundled together.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_unit_if;
    logic        HBUSREQ1;
    logic        HGRANT1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        fetch_error;
    logic [31:0] fetch_err_pc;

    modport master (
        output HBUSREQ1, HADDR, HTRANS, inst_valid, instruction, inst_pc,
               fetch_error, fetch_err_pc,
        input  HGRANT1, HREADY, HRESP, HRDATA, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  HBUSREQ1, HADDR, HTRANS, inst_valid, instruction, inst_pc,
               fetch_error, fetch_err_pc,
        output HGRANT1, HREADY, HRESP, HRDATA, redirect_valid, redirect_pc,
               inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: synchronous instruction buffer with push/pop/flush. Push while
// full is accepted only together with a pop; flush overrides both.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     nRst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!nRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// AHB instruction fetch unit: one outstanding read at a time, buffered in
// fetch_fifo. Optional macro IFU_MISALIGN_CHECK_EN traps misaligned redirects.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic               clock,
    input logic               nRst,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e   state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d, haddr_q, haddr_d, err_pc_q, err_pc_d;
    logic [1:0]   htrans_q, htrans_d;
    logic         busreq_q, busreq_d, discard_q, discard_d, err_q, err_d;
    logic         push, pop, full, empty, data_done;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]  redir_pc;
    logic         redir_bad;
    fetch_entry_t head;

`ifdef IFU_MISALIGN_CHECK_EN
    assign redir_pc  = bus.redirect_pc;
    assign redir_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
    assign redir_bad = 1'b0;
`endif

    // Redirect squashes both the incoming word and the decoder's pop.
    assign data_done = (state_q == DATA) && bus.HREADY;
    assign push      = data_done && !bus.HRESP && !discard_q && !bus.redirect_valid
                       && (!full || pop);
    assign pop       = !empty && bus.inst_ready && !bus.redirect_valid;
    assign count_nxt = bus.redirect_valid ? '0 : (count + CW'(push) - CW'(pop));

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .nRst    (nRst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i ('{pc: fetch_pc_q, instr: bus.HRDATA}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        err_d      = err_q;
        err_pc_d   = err_pc_q;
        case (state_q)
            REQ:  if (bus.HGRANT1 && (count < CW'(FIFO_DEPTH))) state_d = ADDR;
            ADDR: if (bus.HREADY) state_d = DATA;
            DATA: if (bus.HREADY) begin
                discard_d = 1'b0;
                if (bus.HRESP && !discard_q) begin
                    err_d    = 1'b1;
                    err_pc_d = fetch_pc_q;
                    state_d  = HALT;
                end else if (err_q) begin
                    state_d = HALT;
                end else begin
                    if (!discard_q) fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d = (bus.HGRANT1 && (count_nxt < CW'(FIFO_DEPTH))) ? ADDR : REQ;
                end
            end
            default: ;
        endcase

        // An in-flight transfer always runs to completion; only its data is dropped.
        if (bus.redirect_valid) begin
            fetch_pc_d = redir_pc;
            err_d      = redir_bad;
            if (redir_bad) err_pc_d = bus.redirect_pc;
            if (state_q == ADDR || (state_q == DATA && !bus.HREADY)) begin
                discard_d = 1'b1;
            end else if (state_q == DATA) begin
                state_d = redir_bad ? HALT : (bus.HGRANT1 ? ADDR : REQ);
            end else begin
                state_d = redir_bad ? HALT : REQ;
            end
        end

        htrans_d = (state_d == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        haddr_d  = (state_d == ADDR && state_q != ADDR) ? fetch_pc_d : haddr_q;
        busreq_d = (state_d == REQ) && (count_nxt < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!nRst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
            err_pc_q   <= '0;
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            busreq_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
            err_pc_q   <= err_pc_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            busreq_q   <= busreq_d;
        end
    end

    assign bus.HBUSREQ1     = busreq_q;
    assign bus.HTRANS       = htrans_q;
    assign bus.HADDR        = haddr_q;
    assign bus.inst_valid   = !empty;
    assign bus.instruction  = head.instr;
    assign bus.inst_pc      = head.pc;
    assign bus.fetch_error  = err_q;
    assign bus.fetch_err_pc = err_pc_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a zero-wait AHB memory where the
// word at address 4n reads as n.
module tb_inst_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          cyc;
    } rec_t;

    logic        clock = 1'b0;
    logic        nRst  = 1'b0;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    rec_t        dq[$];
    logic [31:0] naddr[$];
    logic        dphase = 1'b0;
    logic [31:0] daddr  = '0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic [31:0] hold_a;
    int          nseq;
    logic        seen8;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clock (clock),
        .nRst  (nRst),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Memory slave: data phase follows an accepted NONSEQ address phase.
    always @(posedge clock) begin
        if (!nRst) dphase <= 1'b0;
        else if (bus.HREADY) begin
            dphase <= (bus.HTRANS == 2'b10);
            daddr  <= bus.HADDR;
        end
    end
    assign bus.HRDATA = daddr >> 2;
    assign bus.HRESP  = err_en && dphase && (daddr == err_addr);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (nRst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid)
            dq.push_back('{bus.inst_pc, bus.instruction, cyc});
        if (nRst && bus.HTRANS == 2'b10 && bus.HREADY)
            naddr.push_back(bus.HADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input logic grant);
        nRst = 1'b0;
        bus.redirect_valid = 1'b0;
        step(2);
        dq.delete();
        naddr.delete();
        bus.HGRANT1 = grant;
        nRst = 1'b1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int k = 0;
        while (!(bus.HTRANS == 2'b10 && bus.HADDR == a) && k < 40) begin
            step();
            k++;
        end
        chk("wait_addr", 32'(k < 40), 32'd1);
    endtask

    initial begin
        bus.HGRANT1 = 1'b0;
        bus.HREADY = 1'b1;
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        step(2);
        chk("rst_busreq", 32'(bus.HBUSREQ1), 32'd0);
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_ivalid", 32'(bus.inst_valid), 32'd0);
        chk("rst_ferr", 32'(bus.fetch_error), 32'd0);
        chk("rst_ferrpc", bus.fetch_err_pc, 32'h0);

        // Streaming with grant held and zero wait states.
        do_reset(1'b1);
        step(8);
        chk("thru_n", 32'(dq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("thru_pc%0d", i), dq[i].pc, 32'(4 * i));
            chk($sformatf("thru_ins%0d", i), dq[i].ins, 32'(i));
        end
        chk("thru_gap1", 32'(dq[1].cyc - dq[0].cyc), 32'd2);
        chk("thru_gap2", 32'(dq[2].cyc - dq[1].cyc), 32'd2);

        // Backpressure: buffer fills, requests stop, then resume.
        bus.inst_ready = 1'b0;
        do_reset(1'b1);
        step(12);
        chk("bp_busreq", 32'(bus.HBUSREQ1), 32'd0);
        chk("bp_nseq", 32'(naddr.size()), 32'd2);
        chk("bp_ivalid", 32'(bus.inst_valid), 32'd1);
        chk("bp_head", bus.inst_pc, 32'h0);
        chk("bp_none", 32'(dq.size()), 32'd0);
        bus.inst_ready = 1'b1;
        step(6);
        chk("bp_pc0", dq[0].pc, 32'h0);
        chk("bp_pc1", dq[1].pc, 32'h4);
        chk("bp_pc2", dq[2].pc, 32'h8);
        chk("bp_ins2", dq[2].ins, 32'h2);

        // Redirect while the fetch of 0x8 is in its data phase.
        do_reset(1'b1);
        wait_addr(32'h8);
        step();
        bus.redirect_pc = 32'h100;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_flush", 32'(bus.inst_valid), 32'd0);
        step(8);
        seen8 = 1'b0;
        foreach (dq[i]) if (dq[i].pc == 32'h8) seen8 = 1'b1;
        chk("rd_no8", 32'(seen8), 32'd0);
        chk("rd_pc", dq[2].pc, 32'h100);
        chk("rd_ins", dq[2].ins, 32'h40);

        // Bus error on 0xC halts fetching until a redirect.
        err_addr = 32'hC;
        err_en = 1'b1;
        do_reset(1'b1);
        step(12);
        chk("er_flag", 32'(bus.fetch_error), 32'd1);
        chk("er_pc", bus.fetch_err_pc, 32'hC);
        chk("er_n", 32'(dq.size()), 32'd3);
        nseq = naddr.size();
        step(5);
        chk("er_noseq", 32'(naddr.size()), 32'(nseq));
        chk("er_busreq", 32'(bus.HBUSREQ1), 32'd0);
        err_en = 1'b0;
        bus.redirect_pc = 32'h20;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        chk("er_clear", 32'(bus.fetch_error), 32'd0);
        step(8);
        chk("er_rpc", dq[3].pc, 32'h20);
        chk("er_rins", dq[3].ins, 32'h8);

        // Grant withheld, then wait states during the address phase.
        do_reset(1'b0);
        step(5);
        chk("ws_noseq", 32'(naddr.size()), 32'd0);
        chk("ws_htrans", 32'(bus.HTRANS), 32'd0);
        chk("ws_busreq", 32'(bus.HBUSREQ1), 32'd1);
        bus.HGRANT1 = 1'b1;
        wait_addr(32'h0);
        bus.HREADY = 1'b0;
        hold_a = bus.HADDR;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ws_haddr%0d", i), bus.HADDR, hold_a);
            chk($sformatf("ws_trans%0d", i), 32'(bus.HTRANS), 32'h2);
        end
        bus.HREADY = 1'b1;
        step(10);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_pc%0d", i), dq[i].pc, 32'(4 * i));
            chk($sformatf("ws_ins%0d", i), dq[i].ins, 32'(i));
        end

        // Reset in the middle of a data phase drops that transfer.
        do_reset(1'b1);
        wait_addr(32'h0);
        step();
        bus.HGRANT1 = 1'b0;
        nRst = 1'b0;
        step();
        nRst = 1'b1;
        step();
        chk("mr_ivalid", 32'(bus.inst_valid), 32'd0);
        chk("mr_htrans", 32'(bus.HTRANS), 32'd0);

        // Misaligned redirect target.
        do_reset(1'b0);
        step();
        bus.redirect_pc = 32'h102;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.HGRANT1 = 1'b1;
        step(6);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("ma_ferr", 32'(bus.fetch_error), 32'd1);
        chk("ma_ferrpc", bus.fetch_err_pc, 32'h102);
        chk("ma_noseq", 32'(naddr.size()), 32'd0);
`else
        chk("ma_ferr", 32'(bus.fetch_error), 32'd0);
        chk("ma_pc", dq[0].pc, 32'h100);
        chk("ma_ins", dq[0].ins, 32'h40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
